// File: rtl/fermat_pkg.sv
// fermat_pkg: shared FSM state type and elaboration-time helpers for the Fermat inverse engine
package fermat_pkg;
  typedef enum logic [2:0] {IDLE, INIT, MUL, SQR, CHK, FIN} state_t;
  function automatic bit modulus_ok(int p, int width);
    if (p < 3 || p >= (1 << width)) return 1'b0;
    for (int d = 2; d * d <= p; d++) if (p % d == 0) return 1'b0;
    return 1'b1;
  endfunction
  function automatic int fermat_latency(int p, int width, bit self_check);
    int k = 0;
    int pc = 0;
    for (int x = p - 2; x != 0; x = x >> 1) begin
      k++;
      pc += x & 1;
    end
    return 2 + (k + pc + int'(self_check)) * (width + 1) + 1;
  endfunction
endpackage

// File: rtl/fermat_theorem_mod_mult.sv
// mod_mult: sequential MSB-first interleaved modular multiplier, WIDTH+1 cycles (ports: clk, reset active-low async, start, a, b -> done, product)
module mod_mult #(
  parameter int WIDTH = 5,
  parameter int P = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH+1:0] PM = (WIDTH + 2)'(P);
  logic [WIDTH-1:0] r, aa, bb;
  logic [CW-1:0] cnt;
  logic busy;
  logic [WIDTH+1:0] t, t1;
  logic [WIDTH-1:0] t2;
  // 2r + bit*b < 3P, so two conditional subtractions bring it back below P
  always_comb begin
    t = {1'b0, r, 1'b0} + (aa[WIDTH-1] ? {2'b00, bb} : '0);
    t1 = t >= PM ? t - PM : t;
    t2 = WIDTH'(t1 >= PM ? t1 - PM : t1);
  end
  // done and product are presented during the final iteration so the caller can capture on that edge
  assign done = busy && cnt == CW'(1);
  assign product = t2;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r <= '0;
      aa <= '0;
      bb <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (start) begin
      r <= '0;
      aa <= a;
      bb <= b;
      cnt <= CW'(WIDTH);
      busy <= 1'b1;
    end else if (busy) begin
      r <= t2;
      aa <= aa << 1;
      cnt <= cnt - CW'(1);
      busy <= cnt != CW'(1);
    end
endmodule

// File: rtl/fermat_theorem.sv
// fermat_theorem: self-starting A^(P-2) mod P inverse engine (ports: clk, reset active-low async -> result, done, inv_ok); macro FERMAT_SELF_CHECK_EN adds a CHK pass driving inv_ok
module fermat_theorem import fermat_pkg::*; #(
  parameter int WIDTH = 5,
  parameter int P = 11,
  parameter int A = 3
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             inv_ok
);
  if (!modulus_ok(P, WIDTH)) begin : g_bad_modulus
    $error("fermat_theorem: P must be a prime >= 3 and below 2**WIDTH");
  end
  localparam int AM = A % P;
  localparam logic [WIDTH-1:0] A_RED = WIDTH'(AM);
  localparam logic [WIDTH-1:0] E0 = WIDTH'(P - 2);
`ifdef FERMAT_SELF_CHECK_EN
  localparam state_t LAST = CHK;
`else
  localparam state_t LAST = FIN;
`endif
  state_t state, next;
  logic [WIDTH-1:0] base, acc, exp_r, exp_nxt, mm_a, mm_b, mm_p;
  logic busy, mm_start, mm_done;
  assign exp_nxt = exp_r >> 1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = INIT;
      INIT: next = E0 == '0 ? FIN : E0[0] ? MUL : SQR;
      MUL: next = mm_done ? SQR : MUL;
      SQR: next = !mm_done ? SQR : exp_nxt == '0 ? LAST : exp_nxt[0] ? MUL : SQR;
      CHK: next = mm_done ? FIN : CHK;
      default: next = FIN;
    endcase
  end
  // one multiplier shared by all three compute states; start fires on the first cycle of each pass
  always_comb begin
    mm_start = (state == MUL || state == SQR || state == CHK) && !busy;
    mm_a = state == MUL ? acc : state == SQR ? base : A_RED;
    mm_b = state == CHK ? acc : base;
  end
  mod_mult #(.WIDTH(WIDTH), .P(P)) u_mm (
    .clk(clk),
    .reset(reset),
    .start(mm_start),
    .a(mm_a),
    .b(mm_b),
    .done(mm_done),
    .product(mm_p)
  );
`ifdef FERMAT_SELF_CHECK_EN
  logic chk, ok_r;
  assign inv_ok = ok_r;
`else
  assign inv_ok = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      base <= '0;
      acc <= '0;
      exp_r <= '0;
      busy <= 1'b0;
      result <= '0;
      done <= 1'b0;
`ifdef FERMAT_SELF_CHECK_EN
      chk <= 1'b0;
      ok_r <= 1'b0;
`endif
    end else begin
      busy <= mm_start | (busy & ~mm_done);
      if (state == INIT) begin
        base <= A_RED;
        acc <= WIDTH'(1);
        exp_r <= E0;
      end
      if (mm_done && state == MUL) acc <= mm_p;
      if (mm_done && state == SQR) begin
        base <= mm_p;
        exp_r <= exp_nxt;
      end
`ifdef FERMAT_SELF_CHECK_EN
      if (mm_done && state == CHK) chk <= mm_p == WIDTH'(1);
      if (state == FIN) ok_r <= chk;
`endif
      if (state == FIN) begin
        result <= acc;
        done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_fermat_theorem.sv
// tb_fermat_theorem: table-driven scoreboard bench over six parameterisations of fermat_theorem
module tb_fermat_theorem;
  localparam int N = 6;
`ifdef FERMAT_SELF_CHECK_EN
  localparam int XL = 6;
  localparam bit SC = 1'b1;
`else
  localparam int XL = 0;
  localparam bit SC = 1'b0;
`endif
  typedef struct {
    int idx;
    logic [4:0] res;
    int lat;
    logic ok;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] res [N];
  logic dn [N];
  logic ok [N];
  vec_t tbl [N];
  vec_t sb [$];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  fermat_theorem #(.WIDTH(5), .P(11), .A(3))  u0 (.clk(clk), .reset(reset), .result(res[0]), .done(dn[0]), .inv_ok(ok[0]));
  fermat_theorem #(.WIDTH(5), .P(11), .A(14)) u1 (.clk(clk), .reset(reset), .result(res[1]), .done(dn[1]), .inv_ok(ok[1]));
  fermat_theorem #(.WIDTH(5), .P(13), .A(2))  u2 (.clk(clk), .reset(reset), .result(res[2]), .done(dn[2]), .inv_ok(ok[2]));
  fermat_theorem #(.WIDTH(5), .P(31), .A(5))  u3 (.clk(clk), .reset(reset), .result(res[3]), .done(dn[3]), .inv_ok(ok[3]));
  fermat_theorem #(.WIDTH(5), .P(11), .A(0))  u4 (.clk(clk), .reset(reset), .result(res[4]), .done(dn[4]), .inv_ok(ok[4]));
  fermat_theorem #(.WIDTH(5), .P(11), .A(22)) u5 (.clk(clk), .reset(reset), .result(res[5]), .done(dn[5]), .inv_ok(ok[5]));
  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask
  task automatic check_reset(string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_result[%0d]", tag, i), int'(res[i]), 0);
      check($sformatf("%s_done[%0d]", tag, i), int'(dn[i]), 0);
      check($sformatf("%s_inv_ok[%0d]", tag, i), int'(ok[i]), 0);
    end
  endtask
  task automatic run(string tag);
    bit seen [N];
    bit partial [N];
    int cyc = 0;
    int left = N;
    vec_t e;
    for (int i = 0; i < N; i++) begin
      sb.push_back(tbl[i]);
      seen[i] = 1'b0;
      partial[i] = 1'b0;
    end
    reset = 1'b1;
    while (left > 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (!seen[i] && dn[i]) begin
          seen[i] = 1'b1;
          left--;
          for (int j = 0; j < sb.size(); j++)
            if (sb[j].idx == i) begin
              e = sb[j];
              sb.delete(j);
              break;
            end
          check($sformatf("%s_result[%0d]", tag, i), int'(res[i]), int'(e.res));
          check($sformatf("%s_latency[%0d]", tag, i), cyc, e.lat);
          check($sformatf("%s_inv_ok[%0d]", tag, i), int'(ok[i]), int'(e.ok));
          check($sformatf("%s_partial_result[%0d]", tag, i), int'(partial[i]), 0);
        end else if (!seen[i] && res[i] != 5'd0) begin
          partial[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < N; i++)
      if (!seen[i]) check($sformatf("%s_timeout_done[%0d]", tag, i), int'(dn[i]), 1);
  endtask
  initial begin
    int chg [N];
    logic [4:0] hold [N];
    tbl[0] = '{0, 5'd4, 39 + XL, SC};
    tbl[1] = '{1, 5'd4, 39 + XL, SC};
    tbl[2] = '{2, 5'd7, 45 + XL, SC};
    tbl[3] = '{3, 5'd25, 57 + XL, SC};
    tbl[4] = '{4, 5'd0, 39 + XL, 1'b0};
    tbl[5] = '{5, 5'd0, 39 + XL, 1'b0};
    #1 reset = 1'b0;
    #2 check_reset("por");
    @(negedge clk);
    run("run1");
    for (int i = 0; i < N; i++) begin
      chg[i] = 0;
      hold[i] = res[i];
    end
    repeat (100) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (res[i] != hold[i] || !dn[i]) chg[i]++;
    end
    for (int i = 0; i < N; i++) begin
      check($sformatf("hold_changes[%0d]", i), chg[i], 0);
      check($sformatf("hold_result[%0d]", i), int'(res[i]), int'(tbl[i].res));
    end
    @(negedge clk);
    #1 reset = 1'b0;
    #1 check_reset("post_done_rst");
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    #1 reset = 1'b0;
    #1 check_reset("mid_rst");
    @(negedge clk);
    run("run2");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fermat_theorem.md
Name: fermat_theorem

Overview:
Self-starting modular-inverse engine. Computes A^-1 mod P by Fermat's little theorem, A^(P-2) mod P, using right-to-left square-and-multiply. Operands are compile-time parameters. Starts automatically when reset is released and holds the answer on `result`. Used as a stand-alone inverse generator and as a reference block for the HE datapath.

Parameters:
- WIDTH, 5, bit width of operands, `result` and internal registers; P < 2^WIDTH required.
- P, 11, prime modulus; must be prime and >= 3. Elaboration-time error otherwise.
- A, 3, value to invert; any non-negative integer, reduced mod P internally.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (low = reset asserted).
- result  output  WIDTH  inverse A^(P-2) mod P; valid while done=1.
- done  output  1  high once result is final; stays high until reset.
- inv_ok  output  1  self-check flag (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): result=0, done=0, inv_ok=0, FSM=IDLE, all datapath registers cleared.
- FSM states: IDLE, INIT, MUL, SQR, (CHK), FIN.
- IDLE: on the first rising edge with reset=1, go to INIT.
- INIT (1 cycle): load base=A mod P, acc=1, exp=P-2.
  - If exp==0, go to FIN.
  - Else if exp[0]=1, go to MUL; otherwise go to SQR.
- MUL: acc <= acc*base mod P via mod_mult, then go to SQR.
- SQR: base <= base*base mod P via mod_mult, then exp <= exp>>1.
  - If the new exp==0, go to FIN (or CHK when the macro is defined).
  - Else go to MUL if the new exp[0]=1, otherwise stay in SQR.
- FIN: result <= acc and done <= 1 in the same edge. Terminal state; outputs are held until reset.
- Each modular multiply takes exactly WIDTH+1 cycles: 1 load cycle, then WIDTH MSB-first interleaved shift-add-reduce iterations.
- Arithmetic: the intermediate is 2*r + bit*b with r,b < P, so it is < 3P. Keep WIDTH+2 internal bits and apply at most two conditional subtractions of P per iteration. Every stored value stays < P.
- Latency (reset release to done=1) = 2 + (k + popcount(P-2))*(WIDTH+1) + 1, where k = bit length of P-2. Defaults: k=4, popcount=2, so 2+6*6+1 = 39 cycles.
- A mod P == 0: the computation runs normally and gives result=0 with done=1. No inverse exists; inv_ok=0.
- Reset asserted mid-computation: immediate abort, outputs return to 0. The computation restarts from IDLE after release.
- result never shows a partial value; it changes only in the FIN transition.

Optional Feature:
- Macro FERMAT_SELF_CHECK_EN.
- Defined:
  - After the last SQR, go to CHK, which runs one extra mod_mult: (A mod P)*acc mod P.
  - inv_ok=1 iff that product == 1. inv_ok is set together with done.
  - Latency grows by WIDTH+1 cycles (defaults: 45).
- Not defined:
  - No CHK state and no extra cycles.
  - inv_ok is tied to constant 0.

Decomposition:
- Package fermat_pkg holds: FSM state enum (IDLE, INIT, MUL, SQR, CHK, FIN), the latency-formula helper function, and a modulus-validity check function.
- One sub-module, mod_mult:
  - Parameters WIDTH, P. Ports clk, reset, start, a, b, done, product.
  - Sequential interleaved modular multiplier, fixed WIDTH+1 cycle latency.
  - Instantiated once and shared between MUL, SQR and CHK.

Test Plan:
- Defaults (A=3, P=11, WIDTH=5): release reset at 10 ns -> done rises 39 cycles later, result=4 (3*4=12≡1); with macro, inv_ok=1 and done at 45 cycles.
- A=14, P=11 -> reduced to 3, result=4. A=2, P=13 -> result=7.
- A=5, P=31, WIDTH=5 -> result=25 (125 mod 31 = 1). Exercises a full-width modulus.
- A=0 or A=22 with P=11 -> result=0, done=1, inv_ok=0.
- Reset pulsed low at cycle 20 of a default run -> result=0 and done=0 immediately; after release, done at +39 cycles with result=4.
- After done, run 100 more cycles -> result and done remain stable.
